n_adder: RTL and testbench
==========================

N_ADDER -- requirements
Module: n_adder

Interface
REQ-001 Parameter N, default 8, meaning operand/sum width in bits (N >= 1).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  N  operand A, two's complement signed.
REQ-005 B  input  N  operand B, two's complement signed.
REQ-006 ci  input  1  carry-in.
REQ-007 S  output  N  registered sum, signed.
REQ-008 co  output  1  registered carry-out of the MSB.
REQ-009 ovf  output  1  registered signed overflow flag; present only when N_ADDER_OVF_EN is defined.

Function
REQ-010 The design SHALL compute {co_next, S_next} = A + B + ci as an (N+1)-bit unsigned sum, with co_next being bit N.
REQ-011 Sum logic SHALL be a ripple-carry chain of N one-bit full-adder cells: c[0]=ci, s[i]=A[i]^B[i]^c[i], c[i+1]=A[i]B[i] | c[i](A[i]^B[i]), co_next=c[N].
REQ-012 S, co (and ovf) SHALL register S_next, co_next (and ovf_next) on every rising clk edge while rst=0; latency is exactly 1 cycle with no enable or handshake.
REQ-013 New operands SHALL be accepted every cycle (throughput 1 per cycle).
REQ-014 Signed overflow SHALL be ovf_next = c[N] ^ c[N-1], i.e. 1 when A and B have equal sign bits and S_next has a different sign bit.
REQ-015 Wrap-around: results beyond N bits SHALL be truncated modulo 2^N in S; no saturation.
REQ-016 Outputs SHALL hold their value between clock edges regardless of input changes.

Reset
REQ-017 When rst=1 at a rising clk edge, S SHALL become 0, co 0 and ovf 0, overriding the sum.
REQ-018 Asserting rst mid-stream SHALL discard the operand sampled at that edge; the first valid result appears one cycle after the first edge with rst=0.
REQ-019 Before the first reset the output values are undefined; no initial values are required.

Configuration
REQ-020 Macro N_ADDER_OVF_EN: when defined, port ovf and its register and logic SHALL exist as specified in REQ-009, REQ-014 and REQ-017.
REQ-021 When N_ADDER_OVF_EN is undefined, port ovf and all overflow logic SHALL be absent; S and co behaviour are unchanged.

Verification (N=8, one cycle after applying inputs, rst=0)
REQ-022 Apply A=5, B=10, ci=0 -> S=15 (0x0F), co=0, ovf=0.
REQ-023 Apply A=30, B=-10 (0xF6), ci=0 -> S=20 (0x14), co=1, ovf=0.
REQ-024 Apply A=5, B=10, ci=1 -> S=16 (0x10), co=0, ovf=0.
REQ-025 Apply A=127, B=1, ci=0 -> S=0x80 (-128), co=0, ovf=1; also apply A=-128, B=-1, ci=0 -> S=0x7F, co=1, ovf=1.
REQ-026 Apply A=127, B=1, then assert rst for one edge -> S=0, co=0, ovf=0 that cycle; release rst -> the next edge yields the sum of the then-current inputs.
REQ-027 Apply 10 random cycles with A, B in [-127,127] and ci in {0,1} -> each registered {co,S} equals the golden (A+B+ci) mod 2^9 of the previous cycle's inputs; run with and without N_ADDER_OVF_EN.

Source files
------------

// File: rtl/n_adder_if.sv
// n_adder_if: operand/result bundle for the registered ripple-carry adder
// Signals: A, B (N-bit signed operands), ci (carry-in),
//          S (N-bit registered sum), co (registered carry-out),
//          ovf (registered signed overflow, only with N_ADDER_OVF_EN)
// Modports: master drives operands and reads results; slave is the adder side.
interface n_adder_if #(
    parameter int N = 8
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic [N-1:0] S;
    logic         co;
`ifdef N_ADDER_OVF_EN
    logic         ovf;
`endif
    modport master (
        output A, B, ci,
`ifdef N_ADDER_OVF_EN
        input  ovf,
`endif
        input  S, co
    );
    modport slave (
        input  A, B, ci,
`ifdef N_ADDER_OVF_EN
        output ovf,
`endif
        output S, co
    );
endinterface

// File: rtl/n_adder.sv
// n_adder: N-bit ripple-carry adder with registered sum, carry-out and optional overflow
// Ports: clk  - clock, all state updates on the rising edge
//        rst  - synchronous active-high reset, clears S, co (and ovf)
//        bus  - n_adder_if.slave: A, B, ci in; S, co (ovf) out
// Optional feature: define N_ADDER_OVF_EN to add the registered signed overflow flag.
module n_adder #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    n_adder_if.slave    bus
);
    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic [N-1:0] r_s;
    logic         r_co;
    assign w_c[0] = bus.ci;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign w_s[i]   = bus.A[i] ^ bus.B[i] ^ w_c[i];
        assign w_c[i+1] = (bus.A[i] & bus.B[i]) | (w_c[i] & (bus.A[i] ^ bus.B[i]));
    end
    always_ff @(posedge clk) begin
        r_s  <= rst ? '0 : w_s;
        r_co <= rst ? 1'b0 : w_c[N];
    end
    assign bus.S  = r_s;
    assign bus.co = r_co;
`ifdef N_ADDER_OVF_EN
    // Carry into and out of the sign bit disagree exactly when the signed result wraps.
    logic r_ovf;
    always_ff @(posedge clk) begin
        r_ovf <= rst ? 1'b0 : (w_c[N] ^ w_c[N-1]);
    end
    assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_n_adder.sv
// tb_n_adder: directed vector table plus reset, hold and random pipelined checks for n_adder
module tb_n_adder;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    n_adder_if #(.N(N)) bus ();
    n_adder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } vec_t;
    vec_t vt[12];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic check_out(input string name, input logic [7:0] s, input logic co, input logic ovf);
        check({name, ".S"}, 32'(bus.S), 32'(s));
        check({name, ".co"}, 32'(bus.co), 32'(co));
`ifdef N_ADDER_OVF_EN
        check({name, ".ovf"}, 32'(bus.ovf), 32'(ovf));
`else
        if (ovf === 1'bx) $display("note: unexpected X in expected ovf for %s", name);
`endif
    endtask
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        bus.A  = a;
        bus.B  = b;
        bus.ci = ci;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [8:0] g;
        logic [7:0] ra, rb;
        logic       rc, gov;
        vt[0]  = '{8'h05, 8'h0A, 1'b0, 8'h0F, 1'b0, 1'b0};
        vt[1]  = '{8'h1E, 8'hF6, 1'b0, 8'h14, 1'b1, 1'b0};
        vt[2]  = '{8'h05, 8'h0A, 1'b1, 8'h10, 1'b0, 1'b0};
        vt[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[4]  = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vt[5]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[8]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vt[9]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vt[10] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[11] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        rst = 1'b1;
        apply(8'h7F, 8'h01, 1'b0);
        check_out("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].a, vt[i].b, vt[i].ci);
            check_out($sformatf("vec%0d", i), vt[i].s, vt[i].co, vt[i].ovf);
        end
        #2;
        bus.A  = 8'h01;
        bus.B  = 8'h02;
        bus.ci = 1'b1;
        @(negedge clk);
        check_out("hold", 8'h00, 1'b1, 1'b0);
        apply(8'h7F, 8'h01, 1'b0);
        check_out("pre_rst", 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        bus.A  = 8'h7F;
        bus.B  = 8'h01;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check_out("mid_rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(8'h03, 8'h04, 1'b0);
        check_out("post_rst", 8'h07, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ra  = 8'($urandom_range(0, 254) - 127);
            rb  = 8'($urandom_range(0, 254) - 127);
            rc  = 1'($urandom_range(0, 1));
            g   = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            gov = (ra[7] == rb[7]) && (g[7] != ra[7]);
            apply(ra, rb, rc);
            check_out($sformatf("rand%0d", k), g[7:0], g[8], gov);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
